// File: rtl/irq_controller_pkg.sv
// Shared types and defaults for the interrupt scheduler.
// Build option: IRQ_CTRL_EDGE_DETECT_EN selects edge- vs level-sensitive requests.
package irq_controller_pkg;

  localparam int IRQ_COUNT_DEFAULT = 8;
  localparam int IRQ_VECTOR_WIDTH  = 5;
  localparam int IRQ_STATE_COUNT   = 3;

  typedef enum logic [1:0] {
    IRQ_STATE_IDLE     = 2'd0,
    IRQ_STATE_DISPATCH = 2'd1,
    IRQ_STATE_HOLDOFF  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_controller_priority_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
// Purely combinational; idx is zero when nothing is requested.
module irq_priority_encoder #(
  parameter int IRQ_COUNT    = 8,
  parameter int VECTOR_WIDTH = 5
) (
  input  logic [IRQ_COUNT-1:0]    req,
  output logic [VECTOR_WIDTH-1:0] idx,
  output logic                    valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = IRQ_COUNT - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx   = VECTOR_WIDTH'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt scheduler: pending latch, priority pick, boundary dispatch.
// Build option: IRQ_CTRL_EDGE_DETECT_EN makes requests rising-edge triggered.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int IRQ_COUNT    = IRQ_COUNT_DEFAULT,
  parameter int VECTOR_WIDTH = IRQ_VECTOR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [IRQ_COUNT-1:0]    irq_in,
  input  logic [IRQ_COUNT-1:0]    pending_clr,
  input  logic                    i_flag,
  input  logic                    insn_done,
  input  logic                    reti_done,
  input  logic                    irq_ack,
  output logic                    irq_take,
  output logic [VECTOR_WIDTH-1:0] irq_vector,
  output logic                    sreg_i_clear,
  output logic                    irq_pending,
  output logic [IRQ_COUNT-1:0]    pending
);

  irq_state_e             state, state_nxt;
  logic [IRQ_COUNT-1:0]   req;
  logic [IRQ_COUNT-1:0]   pend_nxt;
  logic [VECTOR_WIDTH-1:0] win_idx;
  logic                   win_valid;
  logic                   load_vec;

`ifdef IRQ_CTRL_EDGE_DETECT_EN
  logic [IRQ_COUNT-1:0] irq_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_prev <= '0;
    else          irq_prev <= irq_in;
  end

  assign req = irq_in & ~irq_prev;
`else
  assign req = irq_in;
`endif

  // A new request beats any clear landing in the same cycle
  always_comb begin
    pend_nxt = pending;
    for (int k = 0; k < IRQ_COUNT; k++) begin
      if (req[k])
        pend_nxt[k] = 1'b1;
      else if (pending_clr[k] ||
               (irq_ack && irq_vector == VECTOR_WIDTH'(k + 1)))
        pend_nxt[k] = 1'b0;
    end
  end

  irq_priority_encoder #(
    .IRQ_COUNT    (IRQ_COUNT),
    .VECTOR_WIDTH (VECTOR_WIDTH)
  ) u_prio (
    .req   (pending),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    state_nxt = state;
    load_vec  = 1'b0;
    case (state)
      IRQ_STATE_IDLE: begin
        if (insn_done && reti_done) begin
          state_nxt = IRQ_STATE_HOLDOFF;
        end else if (insn_done && i_flag && win_valid) begin
          state_nxt = IRQ_STATE_DISPATCH;
          load_vec  = 1'b1;
        end
      end
      IRQ_STATE_DISPATCH: begin
        if (irq_ack) state_nxt = IRQ_STATE_IDLE;
      end
      IRQ_STATE_HOLDOFF: begin
        if (insn_done && !reti_done) state_nxt = IRQ_STATE_IDLE;
      end
      default: state_nxt = IRQ_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IRQ_STATE_IDLE;
      pending      <= '0;
      irq_vector   <= '0;
      sreg_i_clear <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending      <= pend_nxt;
      sreg_i_clear <= (state == IRQ_STATE_DISPATCH) && irq_ack;
      if (load_vec) irq_vector <= win_idx + VECTOR_WIDTH'(1);
    end
  end

  assign irq_take    = (state == IRQ_STATE_DISPATCH);
  assign irq_pending = |pending;

endmodule
